// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream controller.
package fifo_pkg;

    localparam int DATA_W          = 8;
    localparam int SKID_DEPTH      = 2;
    localparam int FIFO_RD_LATENCY = 1;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } stream_t;

endpackage

// File: rtl/skid_buffer_2.sv
// Two-slot skid buffer: slot0 is the head presented downstream, slot1 absorbs
// the byte that was already in flight when the consumer stalled.
module skid_buffer_2
    import fifo_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [1:0]   occ_q,   occ_d;
    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic         valid_q, valid_d;
    logic         do_pop;

    assign do_pop = pop && (occ_q != 2'd0);

    always_comb begin
        occ_d   = occ_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            unique case ({push, do_pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        slot0_d = push_data;
                        occ_d   = 2'd1;
                    end else if (occ_q == 2'd1) begin
                        slot1_d = push_data;
                        occ_d   = 2'd2;
                    end
                end
                2'b01: begin
                    slot0_d = slot1_q;
                    occ_d   = occ_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the pushed byte lands behind whatever remains.
                    if (occ_q == 2'd1) begin
                        slot0_d = push_data;
                    end else begin
                        slot0_d = slot1_q;
                        slot1_d = push_data;
                    end
                end
                default: ;
            endcase
        end
        valid_d = (occ_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q   <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
            valid_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            valid_q <= valid_d;
        end
    end

    assign occ       = occ_q;
    assign out_valid = valid_q;
    assign out_data  = slot0_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready byte stream at one byte per
// cycle, tracking the single outstanding read so the skid buffer never overflows.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              flush,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rd_en,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              busy
);

    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic [1:0]       occ;
    logic             pop;
    logic [2:0]       level;
    logic [2:0]       limit;

    assign pop   = m_valid && m_ready;
    assign level = {1'b0, occ} + {2'b00, inflight_q};
    assign limit = 3'(SKID_DEPTH) + {2'b00, pop};

    // Issue only if the returning byte is guaranteed a slot; held low while in reset.
    always_comb begin
        fifo_rd_en = rst_n && enable && !fifo_empty && !flush && (level < limit);
        inflight_d = fifo_rd_en;
        xfer_cnt_d = xfer_cnt_q;
        if (pop && !flush) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    skid_buffer_2 #(
        .W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (inflight_q),
        .push_data (fifo_rdata),
        .pop       (pop),
        .occ       (occ),
        .out_valid (m_valid),
        .out_data  (m_data)
    );

    assign xfer_cnt = xfer_cnt_q;
    assign busy     = (occ != 2'd0) || inflight_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural registered-read FIFO.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, flush, m_ready;
    logic        fifo_empty, fifo_rd_en, m_valid, busy;
    logic [7:0]  fifo_rdata, m_data;
    logic [15:0] xfer_cnt;

    logic        enable2, fifo_empty2, fifo_rd_en2, m_valid2, busy2;
    logic [7:0]  fifo_rdata2, m_data2;
    logic [3:0]  xfer_cnt2;

    logic [7:0]  mem [256];
    logic [7:0]  wr_ptr, rd_ptr;
    logic [7:0]  got [$];
    int          rd_cnt, viol;
    int          checks, fails;

    always #5 clk = ~clk;

    fifo_stream_reader dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .xfer_cnt(xfer_cnt), .busy(busy)
    );

    fifo_stream_reader #(.DATA_W(8), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable2), .flush(1'b0),
        .fifo_empty(fifo_empty2), .fifo_rdata(fifo_rdata2), .fifo_rd_en(fifo_rd_en2),
        .m_valid(m_valid2), .m_data(m_data2), .m_ready(1'b1),
        .xfer_cnt(xfer_cnt2), .busy(busy2)
    );

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_empty2 = 1'b0;
    assign fifo_rdata2 = 8'h5A;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rdata <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 8'd1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) got.push_back(m_data);
        if (fifo_rd_en) rd_cnt++;
        if (fifo_rd_en && fifo_empty) viol++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fifo_write(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_ctl: valid=%b rd_en=%b busy=%b expected 0 0 0", m_valid, fifo_rd_en, busy);
        end
        checks++; if (xfer_cnt !== 16'h0 || m_data !== 8'h00) begin
            fails++; $display("FAIL reset_data: cnt=%0h data=%0h expected 0 0", xfer_cnt, m_data);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic ok;
        tick();
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) fifo_write(8'(i));
        enable = 1'b1;
        @(negedge clk);
        checks++; if (fifo_rd_en !== 1'b1) begin
            fails++; $display("FAIL t1_first_rd: rd_en=%b expected 1", fifo_rd_en);
        end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin
            fails++; $display("FAIL t1_latency_early: valid=%b expected 0", m_valid);
        end
        @(negedge clk);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h01) begin
            fails++; $display("FAIL t1_first_byte: valid=%b data=%0h expected 1 01", m_valid, m_data);
        end
        ok = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);
            if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
                ok = 1'b0;
                $display("FAIL t1_seq: byte %0d valid=%b data=%0h expected 1 %0h", i, m_valid, m_data, i);
            end
        end
        checks++; if (!ok) fails++;
        repeat (3) @(negedge clk);
        checks++; if (xfer_cnt !== 16'd8 || busy !== 1'b0 || fifo_empty !== 1'b1) begin
            fails++; $display("FAIL t1_end: cnt=%0d busy=%b empty=%b expected 8 0 1", xfer_cnt, busy, fifo_empty);
        end
    endtask

    task automatic test_backpressure();
        int  rd0;
        logic ok;
        tick();
        enable = 1'b0; m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) fifo_write(8'(i));
        rd0 = rd_cnt;
        enable = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (rd_cnt - rd0 !== 2) begin
            fails++; $display("FAIL t2_reads: got %0d reads expected 2", rd_cnt - rd0);
        end
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (m_valid !== 1'b1 || m_data !== 8'h01 || fifo_rd_en !== 1'b0 || busy !== 1'b1) ok = 1'b0;
        end
        checks++; if (!ok) begin
            fails++; $display("FAIL t2_hold: valid=%b data=%0h rd_en=%b expected 1 01 0", m_valid, m_data, fifo_rd_en);
        end
        tick();
        m_ready = 1'b1;
        ok = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
                ok = 1'b0;
                $display("FAIL t2_drain: byte %0d valid=%b data=%0h expected 1 %0h", i, m_valid, m_data, i);
            end
        end
        checks++; if (!ok) fails++;
        repeat (2) @(negedge clk);
        checks++; if (xfer_cnt !== 16'd16) begin
            fails++; $display("FAIL t2_cnt: cnt=%0d expected 16", xfer_cnt);
        end
    endtask

    task automatic test_empty_idle();
        int   rd0;
        logic ok;
        tick();
        m_ready = 1'b1; enable = 1'b1;
        rd0 = rd_cnt;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (m_valid !== 1'b0) ok = 1'b0;
        end
        checks++; if (!ok || rd_cnt != rd0) begin
            fails++; $display("FAIL t3_idle: reads=%0d valid_seen=%b expected 0 0", rd_cnt - rd0, !ok);
        end
        tick();
        fifo_write(8'hA5);
        @(negedge clk);
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin
            fails++; $display("FAIL t3_early: valid=%b expected 0", m_valid);
        end
        @(negedge clk);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
            fails++; $display("FAIL t3_byte: valid=%b data=%0h expected 1 a5", m_valid, m_data);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_flush();
        logic [15:0] c0;
        int          g0, n;
        logic        ok;
        tick();
        enable = 1'b0; m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) fifo_write(8'(i));
        enable = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h01 || fifo_rd_en !== 1'b0) begin
            fails++; $display("FAIL t4_pre: valid=%b data=%0h rd_en=%b expected 1 01 0", m_valid, m_data, fifo_rd_en);
        end
        c0 = xfer_cnt;
        tick();
        flush = 1'b1;
        @(negedge clk);
        checks++; if (fifo_rd_en !== 1'b0) begin
            fails++; $display("FAIL t4_rd_forced: rd_en=%b expected 0", fifo_rd_en);
        end
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0 || xfer_cnt !== c0) begin
            fails++; $display("FAIL t4_after: valid=%b cnt=%0d expected 0 %0d", m_valid, xfer_cnt, c0);
        end
        n = 0;
        while (m_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h03) begin
            fails++; $display("FAIL t4_next: valid=%b data=%0h expected 1 03", m_valid, m_data);
        end
        tick();
        g0 = got.size();
        m_ready = 1'b1;
        n = 0;
        while (got.size() < g0 + 6 && n < 30) begin
            @(negedge clk);
            n++;
        end
        ok = (got.size() >= g0 + 6);
        for (int i = 0; i < 6 && ok; i++) begin
            if (got[g0 + i] !== 8'(3 + i)) begin
                ok = 1'b0;
                $display("FAIL t4_order: index %0d data=%0h expected %0h", i, got[g0 + i], 3 + i);
            end
        end
        checks++; if (!ok) begin
            fails++; $display("FAIL t4_drain: received %0d bytes expected 6 in order", got.size() - g0);
        end
        repeat (2) @(negedge clk);
        checks++; if (xfer_cnt - c0 !== 16'd6) begin
            fails++; $display("FAIL t4_cnt: delta=%0d expected 6", xfer_cnt - c0);
        end
    endtask

    task automatic test_random_ready();
        logic [15:0] c0;
        int          g0, v0, n;
        logic        ok;
        int          seed_v;
        seed_v = $urandom(32'h5EED);
        tick();
        enable = 1'b0; m_ready = 1'b0;
        for (int i = 0; i < 200; i++) fifo_write(8'(i));
        g0 = got.size(); c0 = xfer_cnt; v0 = viol;
        enable = 1'b1;
        n = 0;
        while (got.size() < g0 + 200 && n < 2000) begin
            tick();
            m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        tick();
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        ok = (got.size() == g0 + 200);
        for (int i = 0; i < 200 && ok; i++) begin
            if (got[g0 + i] !== 8'(i)) begin
                ok = 1'b0;
                $display("FAIL t5_order: index %0d data=%0h expected %0h", i, got[g0 + i], i);
            end
        end
        checks++; if (!ok) begin
            fails++; $display("FAIL t5_stream: received %0d bytes expected 200 in order", got.size() - g0);
        end
        checks++; if (xfer_cnt - c0 !== 16'd200) begin
            fails++; $display("FAIL t5_cnt: delta=%0d expected 200", xfer_cnt - c0);
        end
        checks++; if (viol != v0) begin
            fails++; $display("FAIL t5_rd_empty: %0d reads while empty expected 0", viol - v0);
        end
        seed_v = 0;
    endtask

    task automatic test_async_reset();
        tick();
        m_ready = 1'b1; enable = 1'b1;
        for (int i = 0; i < 10; i++) fifo_write(8'h40 + 8'(i));
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || xfer_cnt !== 16'h0 || busy !== 1'b0) begin
            fails++; $display("FAIL t6_async: valid=%b rd_en=%b cnt=%0h busy=%b expected 0 0 0 0", m_valid, fifo_rd_en, xfer_cnt, busy);
        end
        wr_ptr = rd_ptr;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (m_valid !== 1'b0 || xfer_cnt !== 16'h0) begin
            fails++; $display("FAIL t6_after: valid=%b cnt=%0h expected 0 0", m_valid, xfer_cnt);
        end
    endtask

    task automatic test_cnt_wrap();
        tick();
        enable2 = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        enable2 = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (xfer_cnt2 !== 4'hF) begin
            fails++; $display("FAIL t6_cnt_max: cnt=%0h expected f", xfer_cnt2);
        end
        tick();
        enable2 = 1'b1;
        @(posedge clk);
        #2;
        enable2 = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (xfer_cnt2 !== 4'h0) begin
            fails++; $display("FAIL t6_cnt_wrap: cnt=%0h expected 0", xfer_cnt2);
        end
    endtask

    initial begin
        checks = 0; fails = 0; rd_cnt = 0; viol = 0;
        rst_n = 1'b0; enable = 1'b0; flush = 1'b0; m_ready = 1'b0; enable2 = 1'b0;
        wr_ptr = 8'd0; rd_ptr = 8'd0; fifo_rdata = 8'd0;
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_idle();
        test_flush();
        test_random_ready();
        test_async_reset();
        test_cnt_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side controller for the 8-bit synchronous FIFO (fifo_top). It drains the FIFO through its read_en/empty/data_out port and presents the bytes downstream on a valid/ready stream. It compensates for the FIFO's 1-cycle registered read latency with a 2-entry skid buffer, so it sustains 1 byte/cycle and never loses or duplicates data under backpressure. It sits between fifo_top and any byte consumer (UART TX, packetiser).

Parameters:
DATA_W, 8, byte width; must match fifo_top.
CNT_W, 16, width of the transfer counter.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
enable  in  1  when 0, no new FIFO reads are issued; buffered data still drains.
flush  in  1  synchronous; discards buffered and in-flight bytes.
fifo_empty  in  1  empty flag from fifo_top.
fifo_rdata  in  DATA_W  data_out from fifo_top; valid the cycle after fifo_rd_en.
fifo_rd_en  out  1  read strobe to fifo_top read_en.
m_valid  out  1  downstream data valid.
m_data  out  DATA_W  downstream byte.
m_ready  in  1  downstream accept.
xfer_cnt  out  CNT_W  count of completed downstream handshakes.
busy  out  1  occupancy or in-flight read is non-zero.

Behaviour:
- Reset (rst_n=0, asynchronous): fifo_rd_en=0, m_valid=0, m_data=0, xfer_cnt=0, busy=0, occupancy=0, inflight=0, both buffer slots cleared. Outputs are released on the first clk edge after rst_n rises.
- State:
  - occ: 0..2, buffered bytes.
  - inflight: 0/1, a read was issued last cycle.
  - pop = m_valid & m_ready.
- fifo_rd_en is combinational: enable & !fifo_empty & !flush & (occ + inflight - pop < 2). It is never asserted while fifo_empty=1.
- inflight <= fifo_rd_en, registered.
- Return capture: when inflight=1, fifo_rdata is written into the tail slot on that edge.
- Slot handling:
  - Push and pop in the same cycle keeps occ unchanged.
  - Pop promotes slot1 to slot0.
  - Push when occ=0, or when occ=1 with a pop, writes slot0.
- m_valid = (occ != 0); m_data = slot0. Both are register outputs.
- m_data and m_valid stay stable while m_valid=1 and m_ready=0 (AXI-style hold rule).
- Latency: if fifo_empty is sampled 0 at cycle N, then fifo_rd_en is high in N, the byte is on fifo_rdata in N+1, and m_valid is high in N+2.
- Throughput: with m_ready held 1, one byte per cycle and no bubbles.
- Backpressure: with m_ready=0, at most 2 reads are issued, after which fifo_rd_en stays 0. The limit occ + inflight <= 2 guarantees no overflow.
- Ordering: bytes leave in exact FIFO order.
- enable falling: an in-flight byte is still captured, and buffered bytes still drain.
- flush=1 (sync, has priority over push and pop on that edge):
  - occ and inflight are cleared, m_valid drops next cycle.
  - A byte returning in the flush cycle is dropped.
  - fifo_rd_en is forced 0 in the flush cycle.
  - xfer_cnt is not changed. A pop coincident with flush does not count.
- xfer_cnt increments on each pop and wraps from 2^CNT_W-1 to 0.
- busy = (occ != 0) | inflight.
- Reset mid-operation: all state clears immediately. Bytes already popped from the FIFO are lost. fifo_top is reset by the same rst domain by the integrator.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_W default.
  - Constant SKID_DEPTH = 2.
  - Constant FIFO_RD_LATENCY = 1.
  - Stream typedef {valid, data}.
- One natural sub-module, skid_buffer_2: a 2-slot buffer with push/pop/flush and occupancy output. The top-level holds the read-issue logic, the inflight tracking and xfer_cnt.

Test Plan:
1. Write 0x01..0x08 into fifo_top, enable=1, m_ready=1. Expect m_data 01..08 on 8 consecutive cycles, first m_valid 2 cycles after the first fifo_rd_en, xfer_cnt=8, busy=0 afterwards, fifo_empty=1.
2. FIFO holds 01..08, m_ready=0. Expect exactly 2 fifo_rd_en pulses, m_data=01 held stable, occ=2. Raise m_ready: expect 01..08 in order with no gaps after restart and no duplicates.
3. FIFO empty, enable=1 for 20 cycles. Expect fifo_rd_en=0 and m_valid=0 throughout. Write one byte 0xA5: expect m_valid with m_data=A5 exactly 2 cycles after the FIFO's empty flag deasserts.
4. FIFO holds 01..08, m_ready=0, occ=2, inflight=0, then flush for 1 cycle. Expect m_valid=0 next cycle and xfer_cnt unchanged. Raise m_ready: expect next output 03.
5. Toggle m_ready randomly (seeded, 50%) over 200 bytes 0x00..0xC7 through the FIFO. Expect in-order, loss-free output, xfer_cnt=200, and fifo_rd_en never high while fifo_empty=1.
6. Assert rst_n low mid-stream for 1 cycle (asynchronously, between edges). Expect immediate m_valid=0, fifo_rd_en=0, xfer_cnt=0. Separately preload xfer_cnt to 0xFFFF and do one handshake: expect 0x0000.
